// File: rtl/mod_game_pkg.sv
// Shared types and constants for the Modulus Game puzzle generator.
//   puzzle_state_t : generator FSM states
//   rand_t         : 7-bit value carried on the random bus and puzzle fields
//   next_dividend  : dividend used when a dividend draw gives up
package mod_game_pkg;

    localparam int unsigned RAND_W    = 7;
    localparam int unsigned NUM_RANGE = 100;

    typedef logic [RAND_W-1:0] rand_t;

    localparam rand_t PREV_NONE = 7'h7F;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAW_A  = 3'd1,
        DRAW_B  = 3'd2,
        REDUCE  = 3'd3,
        PRESENT = 3'd4
    } puzzle_state_t;

    // Successor of the previous dividend, wrapping inside 0..NUM_RANGE-1.
    function automatic rand_t next_dividend(input rand_t prev);
        rand_t res;
        if (prev == PREV_NONE || prev >= RAND_W'(NUM_RANGE - 1)) begin
            res = '0;
        end else begin
            res = prev + RAND_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/mod_puzzle_gen_if.sv
// Puzzle generator bus: start request, random stream, puzzle handshake.
//   master : the generator (drives busy, puzzle fields, puzzle_valid)
//   slave  : game controller / rng side (drives start, rand_in, puzzle_ready)
interface mod_puzzle_gen_if;

    logic                 start;
    mod_game_pkg::rand_t  rand_in;
    logic                 busy;
    logic                 puzzle_valid;
    logic                 puzzle_ready;
    mod_game_pkg::rand_t  dividend;
    mod_game_pkg::rand_t  divisor;
    mod_game_pkg::rand_t  remainder;
    logic                 fallback;

    modport master (
        input  start, rand_in, puzzle_ready,
        output busy, puzzle_valid, dividend, divisor, remainder, fallback
    );

    modport slave (
        output start, rand_in, puzzle_ready,
        input  busy, puzzle_valid, dividend, divisor, remainder, fallback
    );

endinterface

// File: rtl/mod_reduce.sv
// Iterative remainder engine: one compare/subtract per enabled clock.
//   load        : capture dividend_in as running remainder and divisor_in
//   step        : perform one subtract if remainder >= divisor
//   divisor     : captured divisor (registered)
//   remainder   : running remainder (registered)
//   done_c      : remainder < divisor, combinational from the registers
module mod_reduce
    import mod_game_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  step,
    input  rand_t dividend_in,
    input  rand_t divisor_in,
    output rand_t divisor,
    output rand_t remainder,
    output logic  done_c
);

    rand_t rem_q, rem_d;
    rand_t div_q, div_d;

    // Subtract is guarded by the compare, so it never underflows.
    always_comb begin
        rem_d  = rem_q;
        div_d  = div_q;
        done_c = (rem_q < div_q);
        if (load) begin
            rem_d = dividend_in;
            div_d = divisor_in;
        end else if (step && !done_c) begin
            rem_d = rem_q - div_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            div_q <= '0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
        end
    end

    assign divisor   = div_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mod_puzzle_gen.sv
// Modulus Game puzzle generator. Draws a dividend and a divisor from the
// free-running random bus with rejection sampling (bounded by MAX_TRIES,
// then a deterministic fallback), reduces dividend mod divisor iteratively
// and presents the puzzle over a valid/ready handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mod_puzzle_gen_if.master (start, rand_in, busy, puzzle_*)
module mod_puzzle_gen
    import mod_game_pkg::*;
#(
    parameter int unsigned DIV_MIN   = 2,
    parameter int unsigned DIV_MAX   = 12,
    parameter int unsigned MAX_TRIES = 15
) (
    input  logic             clk,
    input  logic             rst,
    mod_puzzle_gen_if.master bus
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    puzzle_state_t state_q, state_d;
    rand_t         dividend_q, dividend_d;
    rand_t         prev_q, prev_d;
    logic [TRY_W-1:0] try_q, try_d;
    logic          fallback_q, fallback_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;

    logic          red_load;
    logic          red_step;
    rand_t         red_divisor_in;
    logic          red_done_c;
    logic          a_ok;
    logic          b_ok;
    logic          tries_out;

    assign a_ok      = (bus.rand_in <= RAND_W'(NUM_RANGE - 1)) && (bus.rand_in != prev_q);
    assign b_ok      = (bus.rand_in >= RAND_W'(DIV_MIN)) && (bus.rand_in <= RAND_W'(DIV_MAX));
    assign tries_out = (try_q == TRY_W'(MAX_TRIES));

    // Next-state, draw bookkeeping and reduce-engine control.
    always_comb begin
        state_d        = state_q;
        dividend_d     = dividend_q;
        prev_d         = prev_q;
        try_d          = try_q;
        fallback_d     = fallback_q;
        red_load       = 1'b0;
        red_step       = 1'b0;
        red_divisor_in = RAND_W'(DIV_MIN);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = DRAW_A;
                    fallback_d = 1'b0;
                    try_d      = '0;
                end
            end
            DRAW_A: begin
                // Give-up check wins over the sample seen in that cycle.
                if (tries_out) begin
                    dividend_d = next_dividend(prev_q);
                    prev_d     = next_dividend(prev_q);
                    fallback_d = 1'b1;
                    try_d      = '0;
                    state_d    = DRAW_B;
                end else if (a_ok) begin
                    dividend_d = bus.rand_in;
                    prev_d     = bus.rand_in;
                    try_d      = '0;
                    state_d    = DRAW_B;
                end else begin
                    try_d = try_q + TRY_W'(1);
                end
            end
            DRAW_B: begin
                if (tries_out) begin
                    red_load       = 1'b1;
                    red_divisor_in = RAND_W'(DIV_MIN);
                    fallback_d     = 1'b1;
                    try_d          = '0;
                    state_d        = REDUCE;
                end else if (b_ok) begin
                    red_load       = 1'b1;
                    red_divisor_in = bus.rand_in;
                    try_d          = '0;
                    state_d        = REDUCE;
                end else begin
                    try_d = try_q + TRY_W'(1);
                end
            end
            REDUCE: begin
                red_step = 1'b1;
                if (red_done_c) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.puzzle_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == PRESENT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            prev_q     <= PREV_NONE;
            try_q      <= '0;
            fallback_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            prev_q     <= prev_d;
            try_q      <= try_d;
            fallback_q <= fallback_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    mod_reduce u_reduce (
        .clk         (clk),
        .rst         (rst),
        .load        (red_load),
        .step        (red_step),
        .dividend_in (dividend_q),
        .divisor_in  (red_divisor_in),
        .divisor     (bus.divisor),
        .remainder   (bus.remainder),
        .done_c      (red_done_c)
    );

    assign bus.dividend     = dividend_q;
    assign bus.fallback     = fallback_q;
    assign bus.busy         = busy_q;
    assign bus.puzzle_valid = valid_q;

endmodule

// File: tb/tb_mod_puzzle_gen.sv
// Bench for mod_puzzle_gen: directed puzzles, an arithmetic model of the
// draw/reduce rules, and a per-cycle compare process on the puzzle fields.
module tb_mod_puzzle_gen;

    localparam int DIV_MIN   = 2;
    localparam int DIV_MAX   = 12;
    localparam int MAX_TRIES = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mod_puzzle_gen_if bus();

    mod_puzzle_gen #(
        .DIV_MIN   (DIV_MIN),
        .DIV_MAX   (DIV_MAX),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Expected puzzle held by the model while the DUT should be presenting.
    bit expect_valid = 1'b0;
    int exp_a = 0, exp_b = 0, exp_r = 0, exp_fb = 0;
    int model_prev = 127;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Puzzle rules: one sample per clock, bounded retries, then fallback.
    function automatic void model(input int s[$], input int prev_in,
                                  output int a, output int b, output int r,
                                  output int fb, output int lat, output int prev_out);
        int k = 0;
        int tries = 0;
        int ca = 0;
        int cb = 0;
        int v;
        a  = -1;
        b  = -1;
        fb = 0;
        while (a < 0) begin
            v = s[(k < s.size()) ? k : s.size() - 1];
            ca++;
            k++;
            if (tries == MAX_TRIES) begin
                a  = (prev_in == 127) ? 0 : (prev_in + 1) % 100;
                fb = 1;
            end else if (v <= 99 && v != prev_in) begin
                a = v;
            end else begin
                tries++;
            end
        end
        tries = 0;
        while (b < 0) begin
            v = s[(k < s.size()) ? k : s.size() - 1];
            cb++;
            k++;
            if (tries == MAX_TRIES) begin
                b  = DIV_MIN;
                fb = 1;
            end else if (v >= DIV_MIN && v <= DIV_MAX) begin
                b = v;
            end else begin
                tries++;
            end
        end
        r        = a % b;
        lat      = ca + cb + a / b + 1;
        prev_out = a;
    endfunction

    // Every cycle: fields must match the model while presenting; valid low otherwise.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            if (expect_valid) begin
                check("pv_valid", 32'(bus.puzzle_valid), 32'd1);
                check("pv_busy", 32'(bus.busy), 32'd1);
                check("pv_dividend", 32'(bus.dividend), 32'(exp_a));
                check("pv_divisor", 32'(bus.divisor), 32'(exp_b));
                check("pv_remainder", 32'(bus.remainder), 32'(exp_r));
                check("pv_fallback", 32'(bus.fallback), 32'(exp_fb));
            end else begin
                check("valid_low", 32'(bus.puzzle_valid), 32'd0);
            end
        end
    end

    task automatic run_puzzle(input string name, input int s[$], input int hold,
                              input bit start_mid, input int lit_a, input int lit_b,
                              input int lit_r, input int lit_fb, input int lit_lat);
        int m_a, m_b, m_r, m_fb, m_lat, m_prev;
        int lat = 0;
        bit got = 1'b0;
        model(s, model_prev, m_a, m_b, m_r, m_fb, m_lat, m_prev);
        check({name, "_model_a"}, 32'(m_a), 32'(lit_a));
        check({name, "_model_r"}, 32'(m_r), 32'(lit_r));
        check({name, "_model_lat"}, 32'(m_lat), 32'(lit_lat));
        exp_a  = m_a;
        exp_b  = m_b;
        exp_r  = m_r;
        exp_fb = m_fb;
        model_prev = m_prev;

        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.rand_in = 7'(s[(i < s.size()) ? i : s.size() - 1]);
            @(posedge clk);
            #1;
            if (bus.puzzle_valid) begin
                got = 1'b1;
                lat = i + 1;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(m_lat));
        if (!got) return;

        expect_valid = 1'b1;
        check({name, "_dividend"}, 32'(bus.dividend), 32'(lit_a));
        check({name, "_divisor"}, 32'(bus.divisor), 32'(lit_b));
        check({name, "_remainder"}, 32'(bus.remainder), 32'(lit_r));
        check({name, "_fallback"}, 32'(bus.fallback), 32'(lit_fb));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.rand_in = 7'($urandom_range(0, 127));
            bus.start   = start_mid && (h == 2);
        end
        @(negedge clk);
        bus.start        = start_mid;
        bus.puzzle_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_valid = 1'b0;
        check({name, "_valid_drop"}, 32'(bus.puzzle_valid), 32'd0);
        check({name, "_busy_drop"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.puzzle_ready = 1'b0;
        bus.start        = 1'b0;
        if (start_mid) begin
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                check({name, "_no_requeue"}, 32'(bus.busy), 32'd0);
            end
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_dividend"}, 32'(bus.dividend), 32'd0);
        check({name, "_divisor"}, 32'(bus.divisor), 32'd0);
        check({name, "_remainder"}, 32'(bus.remainder), 32'd0);
        check({name, "_fallback"}, 32'(bus.fallback), 32'd0);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_valid"}, 32'(bus.puzzle_valid), 32'd0);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.rand_in      = 7'd0;
        bus.puzzle_ready = 1'b0;
        rst              = 1'b1;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        model_prev = 127;

        run_puzzle("basic", '{47, 5}, 0, 1'b0, 47, 5, 2, 0, 12);
        run_puzzle("div_reject", '{30, 0, 1, 50, 7}, 0, 1'b0, 30, 7, 2, 0, 10);
        run_puzzle("div20", '{20, 5}, 0, 1'b0, 20, 5, 0, 0, 7);
        run_puzzle("fallback", '{20}, 0, 1'b0, 21, 2, 1, 1, 43);
        run_puzzle("hold", '{63, 9}, 8, 1'b1, 63, 9, 0, 0, 10);

        // Reset in the middle of a long REDUCE.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.rand_in = 7'd99;
        @(negedge clk);
        bus.rand_in = 7'd2;
        @(posedge clk);
        for (int c = 0; c < 10; c++) @(posedge clk);
        #1;
        check("mid_reduce_busy", 32'(bus.busy), 32'd1);
        check("mid_reduce_rem", 32'(bus.remainder), 32'd79);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_prev = 127;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_puzzle("after_reset", '{99, 2}, 1, 1'b0, 99, 2, 1, 0, 52);
        run_puzzle("zero", '{0, 12}, 0, 1'b0, 0, 12, 0, 0, 3);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
